// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: EX/MEM entry -> one data-cache access -> MEM/WB result.
// Optional MISALIGN_CHECK_EN faults misaligned accesses instead of issuing them.
module mem_stage_lsu #(
   parameter int XLEN = 64,
   parameter int RD_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_addr,
   input  logic [XLEN-1:0]   in_wdata,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic              in_is_load,
   input  logic              in_is_store,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_data,
   output logic [RD_W-1:0]   out_rd,
   output logic              out_fault,
   output logic              dc_req_valid,
   input  logic              dc_req_ready,
   output logic [XLEN-1:0]   dc_req_addr,
   output logic              dc_req_write,
   output logic [XLEN-1:0]   dc_req_wdata,
   output logic [XLEN/8-1:0] dc_req_wstrb,
   input  logic              dc_resp_valid,
   input  logic [XLEN-1:0]   dc_resp_data,
   input  logic              snoop_stall
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t state, state_nx, entry_state;

   logic [XLEN-1:0]  l_addr, l_wdata;
   logic [1:0]       l_size;
   logic             l_unsigned, l_load, l_write;
   logic [XLEN-1:0]  data_q;
   logic [RD_W-1:0]  rd_q;
   logic             fault_q;

   logic             in_mem, in_fault, accept;
   logic [1:0]       in_size_eff;

   logic [OFF_W-1:0] off;
   logic [OFF_W+2:0] lane_shift;
   logic [3:0]       nbytes;
   logic [NB-1:0]    strb_base;
   logic [6:0]       nbits;
   logic [XLEN-1:0]  rsh, low_mask, sign_pos, load_ext;
   logic             sign_bit;

   // A 32-bit core has no doubleword access; fold size 3 onto word.
   function automatic logic [1:0] clamp_size(input logic [1:0] s);
      return (XLEN == 32 && s == 2'd3) ? 2'd2 : s;
   endfunction

   assign in_size_eff = clamp_size(in_size);
   assign in_mem      = in_is_load || in_is_store;

`ifdef MISALIGN_CHECK_EN
   logic [3:0] size_mask;
   assign size_mask = (4'd1 << in_size_eff) - 4'd1;
   assign in_fault  = in_mem && ((in_addr[OFF_W-1:0] & size_mask[OFF_W-1:0]) != '0);
`else
   assign in_fault  = 1'b0;
`endif

   // Faulting memory ops bypass the cache and retire like pass-through ops.
   assign entry_state = (in_mem && !in_fault) ? REQ : HOLD;
   assign accept      = in_valid && in_ready;

   always_comb begin
      state_nx     = state;
      in_ready     = 1'b0;
      dc_req_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = entry_state;
         end
         REQ: begin
            dc_req_valid = !snoop_stall;
            if (!snoop_stall && dc_req_ready) state_nx = WAIT;
         end
         WAIT: begin
            if (dc_resp_valid) state_nx = HOLD;
         end
         HOLD: begin
            in_ready = out_ready;
            if (out_ready) state_nx = in_valid ? entry_state : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Request side: everything comes from latched fields so it holds while stalled.
   assign off          = l_addr[OFF_W-1:0];
   assign lane_shift   = {off, 3'b000};
   assign dc_req_addr  = {l_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
   assign dc_req_write = l_write;
   assign dc_req_wdata = l_wdata << lane_shift;
   assign nbytes       = 4'd1 << l_size;
   // Shifting past NB wraps to zero, so the subtract yields all-ones for full width.
   assign strb_base    = (NB'(1) << nbytes) - NB'(1);
   assign dc_req_wstrb = strb_base << off;

   // Load extension via masks, so no zero-width replication at full width.
   assign nbits    = 7'd8 << l_size;
   assign rsh      = dc_resp_data >> lane_shift;
   assign low_mask = (XLEN'(1) << nbits) - XLEN'(1);
   assign sign_pos = XLEN'(1) << (nbits - 7'd1);
   assign sign_bit = !l_unsigned && ((rsh & sign_pos) != '0);
   assign load_ext = (rsh & low_mask) | (sign_bit ? ~low_mask : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         l_addr     <= '0;
         l_wdata    <= '0;
         l_size     <= '0;
         l_unsigned <= 1'b0;
         l_load     <= 1'b0;
         l_write    <= 1'b0;
         data_q     <= '0;
         rd_q       <= '0;
         fault_q    <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            l_addr     <= in_addr;
            l_wdata    <= in_wdata;
            l_size     <= in_size_eff;
            l_unsigned <= in_unsigned;
            l_load     <= in_is_load;
            l_write    <= in_is_store && !in_is_load;
            data_q     <= in_mem ? '0 : in_addr;
            rd_q       <= in_rd;
            fault_q    <= in_fault;
         end else if (state == WAIT && dc_resp_valid) begin
            data_q <= l_load ? load_ext : '0;
         end
      end
   end

   assign out_valid = (state == HOLD);
   assign out_data  = data_q;
   assign out_rd    = rd_q;
   assign out_fault = fault_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu (XLEN=64): directed table, corner sequences, random ops.
module tb_mem_stage_lsu;
   localparam int XLEN = 64;
   localparam int RD_W = 5;
`ifdef MISALIGN_CHECK_EN
   localparam bit MCHK = 1'b1;
`else
   localparam bit MCHK = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid, in_ready;
   logic [63:0]     in_addr, in_wdata;
   logic [1:0]      in_size;
   logic            in_unsigned, in_is_load, in_is_store;
   logic [4:0]      in_rd;
   logic            out_valid, out_ready;
   logic [63:0]     out_data;
   logic [4:0]      out_rd;
   logic            out_fault;
   logic            dc_req_valid, dc_req_ready, dc_req_write;
   logic [63:0]     dc_req_addr, dc_req_wdata;
   logic [7:0]      dc_req_wstrb;
   logic            dc_resp_valid;
   logic [63:0]     dc_resp_data;
   logic            snoop_stall;

   mem_stage_lsu #(.XLEN(XLEN), .RD_W(RD_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_is_load(in_is_load),
      .in_is_store(in_is_store), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
      .out_fault(out_fault),
      .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
      .dc_req_write(dc_req_write), .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
      .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data), .snoop_stall(snoop_stall)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [1:0]  size;
      logic        uns, ld, st;
      logic [4:0]  rd;
      logic [63:0] resp;
      logic [63:0] exp_data;
      logic        exp_fault;
      logic [63:0] exp_raddr;
      logic        exp_write;
      logic [7:0]  exp_wstrb;
      logic [63:0] exp_wdata;
   } vec_t;

   int n_vec = 0;
   int n_bad = 0;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [1:0] size, input logic uns, input logic ld,
                               input logic st, input logic [4:0] rd, input logic [63:0] resp,
                               input logic [63:0] exp_data, input logic exp_fault,
                               input logic [63:0] exp_raddr, input logic exp_write,
                               input logic [7:0] exp_wstrb, input logic [63:0] exp_wdata);
      vec_t v;
      v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns; v.ld = ld; v.st = st;
      v.rd = rd; v.resp = resp; v.exp_data = exp_data; v.exp_fault = exp_fault;
      v.exp_raddr = exp_raddr; v.exp_write = exp_write; v.exp_wstrb = exp_wstrb;
      v.exp_wdata = exp_wdata;
      return v;
   endfunction

   // Reference: byte-by-byte view of the addressed word, independent of the RTL's masks.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      int off = int'(v.addr[2:0]);
      int nb  = 1 << v.size;
      logic mem = v.ld || v.st;
      logic [63:0] d = '0;
      for (int i = 0; i < nb; i++)
         if (off + i < 8) d[8*i +: 8] = v.resp[8*(off+i) +: 8];
      if (!v.uns && nb < 8 && d[8*nb-1])
         for (int i = 8*nb; i < 64; i++) d[i] = 1'b1;
      r.exp_fault = MCHK && mem && ((off % nb) != 0);
      r.exp_raddr = {v.addr[63:3], 3'b000};
      r.exp_write = v.st && !v.ld;
      r.exp_wdata = v.wdata << (8*off);
      for (int b = 0; b < 8; b++) r.exp_wstrb[b] = (b >= off) && (b < off + nb);
      if (r.exp_fault)  r.exp_data = '0;
      else if (!mem)    r.exp_data = v.addr;
      else if (v.ld)    r.exp_data = d;
      else              r.exp_data = '0;
      return r;
   endfunction

   task automatic run_vec(input vec_t v, input int rdly, input int sdly);
      logic direct = !(v.ld || v.st) || v.exp_fault;
      int lat;
      @(negedge clk);
      in_addr = v.addr; in_wdata = v.wdata; in_size = v.size; in_unsigned = v.uns;
      in_is_load = v.ld; in_is_store = v.st; in_rd = v.rd; in_valid = 1'b1;
      dc_resp_data = v.resp;
      chk("in_ready_idle", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      if (!direct) begin
         chk("req_valid", dc_req_valid, 1);
         chk("req_addr", dc_req_addr, v.exp_raddr);
         chk("req_write", dc_req_write, v.exp_write);
         if (v.exp_write) begin
            chk("req_wstrb", dc_req_wstrb, v.exp_wstrb);
            chk("req_wdata", dc_req_wdata, v.exp_wdata);
         end
         repeat (rdly) begin
            @(negedge clk); lat++;
            chk("req_held", dc_req_valid, 1);
            chk("req_addr_held", dc_req_addr, v.exp_raddr);
         end
         dc_req_ready = 1'b1;
         @(negedge clk); lat++;
         dc_req_ready = 1'b0;
         chk("req_dropped", dc_req_valid, 0);
         repeat (sdly) begin
            chk("early_out", out_valid, 0);
            @(negedge clk); lat++;
         end
         dc_resp_valid = 1'b1;
         @(negedge clk); lat++;
         dc_resp_valid = 1'b0;
      end else begin
         chk("no_req", dc_req_valid, 0);
      end
      for (int k = 0; k < 10 && !out_valid; k++) begin
         @(negedge clk); lat++;
      end
      chk("latency", lat, direct ? 1 : 3 + rdly + sdly);
      chk("out_data", out_data, v.exp_data);
      chk("out_rd", out_rd, v.rd);
      chk("out_fault", out_fault, v.exp_fault);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("out_drop", out_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      reset = 1'b1; in_valid = 0; in_addr = 0; in_wdata = 0; in_size = 0; in_unsigned = 0;
      in_is_load = 0; in_is_store = 0; in_rd = 0; out_ready = 0; dc_req_ready = 0;
      dc_resp_valid = 0; dc_resp_data = 0; snoop_stall = 0;

      tbl[0]  = mk(64'h1003, 0, 2'd0, 0, 1, 0, 5'd1, 64'h0000_0000_8000_0000,
                   64'hFFFF_FFFF_FFFF_FF80, 0, 64'h1000, 0, 8'h00, 0);
      tbl[1]  = mk(64'h2006, 64'hBEEF, 2'd1, 0, 0, 1, 5'd2, 0,
                   0, 0, 64'h2000, 1, 8'hC0, 64'hBEEF_0000_0000_0000);
      tbl[2]  = mk(64'h1234, 0, 2'd0, 0, 0, 0, 5'd3, 0, 64'h1234, 0, 0, 0, 8'h00, 0);
      tbl[3]  = mk(64'h1002, 0, 2'd2, 0, 1, 0, 5'd4, 64'h1122_3344_5566_7788,
                   MCHK ? 64'h0 : 64'h3344_5566, MCHK, 64'h1000, 0, 8'h00, 0);
      tbl[4]  = mk(64'h1006, 0, 2'd2, 0, 1, 0, 5'd5, 64'h8899_0000_0000_0000,
                   MCHK ? 64'h0 : 64'h8899, MCHK, 64'h1000, 0, 8'h00, 0);
      tbl[5]  = mk(64'h3000, 0, 2'd3, 1, 1, 0, 5'd6, 64'h8000_0000_0000_0001,
                   64'h8000_0000_0000_0001, 0, 64'h3000, 0, 8'h00, 0);
      tbl[6]  = mk(64'h4005, 0, 2'd1, 1, 1, 0, 5'd7, 64'hAABB_CCDD_EEFF_0011,
                   MCHK ? 64'h0 : 64'hBBCC, MCHK, 64'h4000, 0, 8'h00, 0);
      tbl[7]  = mk(64'h10F7, 64'h1234_5678_9ABC_DEAB, 2'd0, 0, 0, 1, 5'd8, 0,
                   0, 0, 64'h10F0, 1, 8'h80, 64'hAB00_0000_0000_0000);
      tbl[8]  = mk(64'h2000, 64'hDEAD_BEEF_CAFE_F00D, 2'd3, 0, 0, 1, 5'd9, 0,
                   0, 0, 64'h2000, 1, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
      tbl[9]  = mk(64'h7004, 64'h55, 2'd2, 0, 1, 1, 5'd10, 64'hF000_0001_0000_0000,
                   64'hFFFF_FFFF_F000_0001, 0, 64'h7000, 0, 8'h00, 0);
      tbl[10] = mk(64'h8002, 0, 2'd1, 0, 1, 0, 5'd11, 64'h0000_0000_8001_0000,
                   64'hFFFF_FFFF_FFFF_8001, 0, 64'h8000, 0, 8'h00, 0);
      tbl[11] = mk(64'h9006, 64'hCAFE_BABE, 2'd2, 0, 0, 1, 5'd12, 0,
                   0, MCHK, 64'h9000, 1, 8'hC0, 64'hBABE_0000_0000_0000);

      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_valid", dc_req_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_out_fault", out_fault, 0);
      reset = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(tbl[i], 0, 0);

      // Snoop stall: cache ready but no request may go out while the stall is high.
      @(negedge clk);
      in_addr = 64'h5008; in_size = 2'd3; in_unsigned = 0; in_is_load = 1; in_is_store = 0;
      in_rd = 5'd13; in_valid = 1'b1; snoop_stall = 1'b1; dc_req_ready = 1'b1;
      dc_resp_data = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("snoop_no_req", dc_req_valid, 0);
         chk("snoop_out_valid", out_valid, 0);
         @(negedge clk);
      end
      snoop_stall = 1'b0;
      #1;
      chk("snoop_req_rise", dc_req_valid, 1);
      chk("snoop_addr", dc_req_addr, 64'h5008);
      @(negedge clk);
      dc_req_ready = 1'b0;
      dc_resp_valid = 1'b1;
      @(negedge clk);
      dc_resp_valid = 1'b0;
      chk("snoop_out_valid_hold", out_valid, 1);
      chk("snoop_out_data", out_data, 64'h0123_4567_89AB_CDEF);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;

      // Back-to-back pass-through ops with out_ready held high.
      out_ready = 1'b1;
      in_is_load = 0; in_is_store = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("b2b_out_valid", out_valid, 1);
            chk("b2b_out_data", out_data, 64'h100 + i - 1);
            chk("b2b_out_rd", out_rd, i - 1);
            chk("b2b_in_ready", in_ready, 1);
            chk("b2b_no_req", dc_req_valid, 0);
         end
         in_addr = 64'h100 + i; in_rd = 5'(i); in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_last", out_data, 64'h105);
      @(negedge clk);
      chk("b2b_drain", out_valid, 0);
      out_ready = 1'b0;

      // Reset while waiting on the cache; the late response must be ignored.
      @(negedge clk);
      in_addr = 64'h6000; in_size = 2'd3; in_is_load = 1; in_rd = 5'd7; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; dc_req_ready = 1'b1;
      @(negedge clk);
      dc_req_ready = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; dc_resp_valid = 1'b1; dc_resp_data = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      dc_resp_valid = 1'b0;
      chk("rstw_out_valid", out_valid, 0);
      chk("rstw_out_data", out_data, 0);
      chk("rstw_out_rd", out_rd, 0);
      chk("rstw_in_ready", in_ready, 1);
      chk("rstw_req_valid", dc_req_valid, 0);
      @(negedge clk);
      chk("rstw_still_idle", out_valid, 0);

      // Randomised ops against the reference model.
      for (int i = 0; i < 60; i++) begin
         int kind = int'($urandom_range(0, 3));
         v.addr = {$urandom, $urandom}; v.wdata = {$urandom, $urandom};
         v.size = 2'($urandom_range(0, 3)); v.uns = 1'($urandom);
         v.ld = (kind == 1 || kind == 3); v.st = (kind == 2 || kind == 3);
         v.rd = 5'($urandom); v.resp = {$urandom, $urandom};
         v = model(v);
         run_vec(v, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
